// File: rtl/pc_halt_monitor_pkg.sv
// Shared types for the PC halt monitor and its bench.
//   halt_cause_t : why the monitor stopped (NONE/ADDR/STALL/TIMEOUT)
//   mon_state_t  : monitor FSM states (ARM/RUN/HALTED)
//   HALT_ADDR_DEF: default end-of-program PC
package xgriscv_mon_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ADDR    = 2'd1,
    CAUSE_STALL   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_t;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_t;

  localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_0CCC;

endpackage

// File: rtl/pc_trace_ring.sv
// PC history ring buffer.
// Ports:
//   clk, rstn (sync, active-high)  - clock / reset (clears pointer and all entries)
//   push, din                      - write din at wptr, then advance wptr
//   idx                            - history index, 0 = most recent push
//   dout                           - combinational read of entry[wptr-1-idx]
module pc_trace_ring #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [31:0]   din,
  input  logic [IW-1:0] idx,
  output logic [31:0]   dout
);

  logic [DEPTH-1:0][31:0] entry;
  logic [IW-1:0]          wptr;
  logic [IW-1:0]          rptr;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign rptr = wptr - IW'(1) - idx;
  assign dout = entry[rptr];

  always_ff @(posedge clk) begin
    if (rstn) begin
      entry <= '0;
      wptr  <= '0;
    end else if (push) begin
      entry[wptr] <= din;
      wptr        <= wptr + IW'(1);
    end
  end

endmodule

// File: rtl/pc_halt_monitor.sv
// End-of-program detector watching the core PC.
// Halts (sticky until reset) when PC hits HALT_ADDR, PC is unchanged for
// STALL_LIMIT consecutive samples, or cycle_cnt reaches TIMEOUT
// (priority ADDR > STALL > TIMEOUT). Also counts cycles and PC changes.
// Optional feature: define PC_TRACE_BUFFER_EN to build the PC history ring;
// otherwise trace_pc is tied to 0 and trace_idx is ignored.
// Ports:
//   clk, rstn (sync, active-high), en (hold all state when low)
//   pc            - sampled core PC
//   halt, halt_cause, halt_pc - registered halt status
//   cycle_cnt, pc_change_cnt  - saturating statistics
//   trace_idx, trace_pc       - PC history read port
module pc_halt_monitor
  import xgriscv_mon_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR   = HALT_ADDR_DEF,
  parameter int          STALL_LIMIT = 16,
  parameter int          TIMEOUT     = 100000,
  parameter int          CNT_W       = 32,
  parameter int          TRACE_DEPTH = 8,
  parameter int          IW          = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [31:0]      pc,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] pc_change_cnt,
  input  logic [IW-1:0]    trace_idx,
  output logic [31:0]      trace_pc
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  mon_state_t       state;
  halt_cause_t      cause;
  logic [31:0]      prev_pc;
  logic [SW-1:0]    stall_cnt;

  logic             pc_chg;
  logic [CNT_W-1:0] cyc_nxt;
  logic [CNT_W-1:0] chg_nxt;
  logic [SW-1:0]    stall_nxt;
  halt_cause_t      cause_nxt;
  logic             push;

  assign halt_cause = cause;

  // Post-update values used by the RUN-state halt check.
  always_comb begin
    pc_chg    = (pc != prev_pc);
    cyc_nxt   = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    chg_nxt   = (pc_change_cnt == '1) ? pc_change_cnt : pc_change_cnt + CNT_W'(1);
    stall_nxt = pc_chg ? '0 : ((stall_cnt == '1) ? stall_cnt : stall_cnt + SW'(1));
    cause_nxt = CAUSE_NONE;
    if (pc == HALT_ADDR)                  cause_nxt = CAUSE_ADDR;
    else if (stall_nxt == SW'(STALL_LIMIT - 1)) cause_nxt = CAUSE_STALL;
    else if (cyc_nxt == CNT_W'(TIMEOUT))  cause_nxt = CAUSE_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state         <= ST_ARM;
      halt          <= 1'b0;
      cause         <= CAUSE_NONE;
      halt_pc       <= '0;
      cycle_cnt     <= '0;
      pc_change_cnt <= '0;
      prev_pc       <= '0;
      stall_cnt     <= '0;
    end else if (en) begin
      case (state)
        ST_ARM: begin
          prev_pc   <= pc;
          cycle_cnt <= CNT_W'(1);
          stall_cnt <= '0;
          if (pc == HALT_ADDR) begin
            state   <= ST_HALTED;
            halt    <= 1'b1;
            cause   <= CAUSE_ADDR;
            halt_pc <= pc;
          end else begin
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          cycle_cnt <= cyc_nxt;
          stall_cnt <= stall_nxt;
          prev_pc   <= pc;
          if (pc_chg) pc_change_cnt <= chg_nxt;
          if (cause_nxt != CAUSE_NONE) begin
            state   <= ST_HALTED;
            halt    <= 1'b1;
            cause   <= cause_nxt;
            halt_pc <= pc;
          end
        end
        default: ; // HALTED: frozen until reset
      endcase
    end
  end

  // First armed sample always enters history; afterwards only PC changes.
  assign push = !rstn && en &&
                ((state == ST_ARM) || ((state == ST_RUN) && pc_chg));

`ifdef PC_TRACE_BUFFER_EN
  pc_trace_ring #(.DEPTH(TRACE_DEPTH), .IW(IW)) u_ring (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .din  (pc),
    .idx  (trace_idx),
    .dout (trace_pc)
  );
`else
  logic unused_trace;
  assign unused_trace = push ^ (^trace_idx);
  assign trace_pc     = 32'h0;
`endif

endmodule

// File: tb/tb_pc_halt_monitor.sv
// Directed bench for pc_halt_monitor. Instance a uses default parameters;
// instance b shares the inputs but has TIMEOUT=50 for the budget tests.
module tb_pc_halt_monitor;
  import xgriscv_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic [31:0] pc = '0;
  logic [2:0]  trace_idx = '0;

  logic        halt_a, halt_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] hpc_a, hpc_b, tpc_a, tpc_b;
  logic [31:0] cyc_a, cyc_b, chg_a, chg_b;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  pc_halt_monitor u_a (
    .clk(clk), .rstn(rstn), .en(en), .pc(pc),
    .halt(halt_a), .halt_cause(cause_a), .halt_pc(hpc_a),
    .cycle_cnt(cyc_a), .pc_change_cnt(chg_a),
    .trace_idx(trace_idx), .trace_pc(tpc_a)
  );

  pc_halt_monitor #(.TIMEOUT(50)) u_b (
    .clk(clk), .rstn(rstn), .en(en), .pc(pc),
    .halt(halt_b), .halt_cause(cause_b), .halt_pc(hpc_b),
    .cycle_cnt(cyc_b), .pc_change_cnt(chg_b),
    .trace_idx(trace_idx), .trace_pc(tpc_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1; en = 1'b1;
    step();
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; en = 1'b1; pc = HALT_ADDR_DEF; // reset beats a halt sample
    step(); step();
    total++;
    if ({halt_a, cause_a, hpc_a, cyc_a, chg_a} !== '0) $display("FAIL reset_outputs got halt=%0d cause=%0d hpc=%h cyc=%0d chg=%0d want all 0", halt_a, cause_a, hpc_a, cyc_a, chg_a);
    else pass_cnt++;
    total++;
    if (tpc_a !== 32'h0) $display("FAIL reset_trace got %h want 0", tpc_a);
    else pass_cnt++;
    rstn = 1'b0;
  endtask

  task automatic test_linear();
    do_reset();
    for (int i = 0; i < 819; i++) begin pc = i * 4; step(); end
    total++;
    if (halt_a !== 1'b0) $display("FAIL linear_early_halt got %0d want 0", halt_a);
    else pass_cnt++;
    pc = 32'hCCC; step();
    total++;
    if ({halt_a, cause_a} !== 3'b1_01) $display("FAIL linear_halt got halt=%0d cause=%0d want 1/1", halt_a, cause_a);
    else pass_cnt++;
    total++;
    if (hpc_a !== 32'hCCC) $display("FAIL linear_halt_pc got %h want ccc", hpc_a);
    else pass_cnt++;
    total++;
    if (cyc_a !== 32'd820 || chg_a !== 32'd819) $display("FAIL linear_counts got cyc=%0d chg=%0d want 820/819", cyc_a, chg_a);
    else pass_cnt++;
    // HALTED ignores further input
    pc = 32'h40; step(); step();
    total++;
    if (cyc_a !== 32'd820 || chg_a !== 32'd819 || hpc_a !== 32'hCCC) $display("FAIL halted_frozen got cyc=%0d chg=%0d hpc=%h want 820/819/ccc", cyc_a, chg_a, hpc_a);
    else pass_cnt++;
  endtask

  task automatic test_stall_gap();
    do_reset();
    pc = 0; step(); pc = 4; step(); pc = 8; step();
    for (int i = 0; i < 5; i++) step();      // 6 samples of 8 so far
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (halt_a !== 1'b0 || cyc_a !== 32'd8 || chg_a !== 32'd2) $display("FAIL en_gap_hold got halt=%0d cyc=%0d chg=%0d want 0/8/2", halt_a, cyc_a, chg_a);
    else pass_cnt++;
    en = 1'b1;
    for (int i = 0; i < 9; i++) step();      // 15 samples of 8
    total++;
    if (halt_a !== 1'b0) $display("FAIL stall_early got %0d want 0", halt_a);
    else pass_cnt++;
    step();                                  // 16th sample
    total++;
    if ({halt_a, cause_a} !== 3'b1_10 || hpc_a !== 32'h8) $display("FAIL stall_halt got halt=%0d cause=%0d hpc=%h want 1/2/8", halt_a, cause_a, hpc_a);
    else pass_cnt++;
    total++;
    if (chg_a !== 32'd2 || cyc_a !== 32'd18) $display("FAIL stall_counts got chg=%0d cyc=%0d want 2/18", chg_a, cyc_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_halted();
    rstn = 1'b1; step(); rstn = 1'b0;
    total++;
    if ({halt_a, cause_a, hpc_a, cyc_a, chg_a} !== '0) $display("FAIL reset_halted got halt=%0d cause=%0d cyc=%0d want 0", halt_a, cause_a, cyc_a);
    else pass_cnt++;
    pc = 32'h40; step();                     // back in ARM: first sample
    total++;
    if (cyc_a !== 32'd1 || chg_a !== 32'd0 || halt_a !== 1'b0) $display("FAIL rearm got cyc=%0d chg=%0d halt=%0d want 1/0/0", cyc_a, chg_a, halt_a);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 49; i++) begin pc = (i % 2) * 4; step(); end
    total++;
    if (halt_b !== 1'b0) $display("FAIL timeout_early got %0d want 0", halt_b);
    else pass_cnt++;
    pc = 4; step();
    total++;
    if ({halt_b, cause_b} !== 3'b1_11 || cyc_b !== 32'd50 || hpc_b !== 32'h4 || chg_b !== 32'd49) $display("FAIL timeout_halt got halt=%0d cause=%0d cyc=%0d hpc=%h chg=%0d want 1/3/50/4/49", halt_b, cause_b, cyc_b, hpc_b, chg_b);
    else pass_cnt++;
    do_reset();
    for (int i = 0; i < 49; i++) begin pc = (i % 2) * 4; step(); end
    pc = HALT_ADDR_DEF; step();
    total++;
    if ({halt_b, cause_b} !== 3'b1_01 || cyc_b !== 32'd50 || hpc_b !== 32'hCCC) $display("FAIL timeout_vs_addr got halt=%0d cause=%0d cyc=%0d hpc=%h want 1/1/50/ccc", halt_b, cause_b, cyc_b, hpc_b);
    else pass_cnt++;
  endtask

  task automatic test_trace();
    logic [31:0] e0, e3, e7;
    do_reset();
    for (int i = 0; i < 3; i++) begin pc = 32'h100 + i * 4; step(); end
    trace_idx = 3'd5; #1;
    total++;
    if (tpc_a !== 32'h0) $display("FAIL trace_unwritten got %h want 0", tpc_a);
    else pass_cnt++;
`ifdef PC_TRACE_BUFFER_EN
    e0 = 32'h108;
`else
    e0 = 32'h0;
`endif
    trace_idx = 3'd0; #1;
    total++;
    if (tpc_a !== e0) $display("FAIL trace_3push_idx0 got %h want %h", tpc_a, e0);
    else pass_cnt++;
    for (int i = 3; i < 10; i++) begin pc = 32'h100 + i * 4; step(); end
`ifdef PC_TRACE_BUFFER_EN
    e0 = 32'h124; e3 = 32'h118; e7 = 32'h108;
`else
    e0 = 32'h0; e3 = 32'h0; e7 = 32'h0;
`endif
    trace_idx = 3'd0; #1;
    total++;
    if (tpc_a !== e0) $display("FAIL trace_idx0 got %h want %h", tpc_a, e0);
    else pass_cnt++;
    trace_idx = 3'd3; #1;
    total++;
    if (tpc_a !== e3) $display("FAIL trace_idx3 got %h want %h", tpc_a, e3);
    else pass_cnt++;
    trace_idx = 3'd7; #1;
    total++;
    if (tpc_a !== e7) $display("FAIL trace_idx7_wrap got %h want %h", tpc_a, e7);
    else pass_cnt++;
    total++;
    if (halt_a !== 1'b0 || cyc_a !== 32'd10 || chg_a !== 32'd9) $display("FAIL trace_counts got halt=%0d cyc=%0d chg=%0d want 0/10/9", halt_a, cyc_a, chg_a);
    else pass_cnt++;
    trace_idx = 3'd0;
  endtask

  initial begin
    test_reset();
    test_linear();
    test_stall_gap();
    test_reset_halted();
    test_timeout();
    test_trace();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pc_halt_monitor.md
Name: pc_halt_monitor

Overview:
Downstream observer of the single-cycle core's `pc` output. It counts cycles and PC changes, and detects end-of-program. Three halt causes: the PC reaches a fixed halt address, the PC stays unchanged (self-loop) for too long, or a cycle budget runs out. It gives the simulation bench and the board top a single registered `halt` flag plus statistics, which replaces the ad-hoc PC compare in the bench.

Parameters:
- HALT_ADDR, 32'h00000CCC, PC value that means program end (address of the last instruction).
- STALL_LIMIT, 16, consecutive cycles with unchanged PC that mean halt; must be ≥ 2.
- TIMEOUT, 100000, cycle budget; halt when `cycle_cnt` reaches this value.
- CNT_W, 32, width of the statistics counters.
- TRACE_DEPTH, 8, PC history depth; power of two.

Ports:
- clk, input, 1: core clock; single clock domain.
- rstn, input, 1: synchronous, active-high reset (port keeps the codebase name `rstn`; 1 = reset asserted).
- en, input, 1: monitor enable; when low, no state or counter changes.
- pc, input, 32: current core PC, sampled on the rising clk edge.
- halt, output, 1: registered halt flag; sticky until reset.
- halt_cause, output, 2: 0 NONE, 1 ADDR, 2 STALL, 3 TIMEOUT.
- halt_pc, output, 32: PC sampled in the triggering cycle.
- cycle_cnt, output, CNT_W: enabled cycles since arm.
- pc_change_cnt, output, CNT_W: number of cycles where `pc` ≠ previous sample.
- trace_idx, input, $clog2(TRACE_DEPTH): history index; 0 = most recent.
- trace_pc, output, 32: PC history entry selected by `trace_idx`.

Behaviour:
- Reset (`rstn`=1 at clk edge): state ARM; `halt`=0, `halt_cause`=0, `halt_pc`=0, `cycle_cnt`=0, `pc_change_cnt`=0. Internal `prev_pc`, stall counter and trace write pointer = 0; all trace entries = 0.
- Reset has priority over everything, including a halt-triggering sample in the same cycle. Reset mid-run clears all outputs next cycle.

State machine: ARM → RUN → HALTED. HALTED exits only through reset.

- ARM, `en`=1:
  - `prev_pc` ← `pc`, `cycle_cnt` ← 1, stall counter ← 0.
  - Push `pc` into trace.
  - If `pc` == HALT_ADDR: go to HALTED with cause ADDR; else go to RUN.
  - `pc_change_cnt` does not increment in this cycle.
- RUN, `en`=1:
  - `cycle_cnt` += 1.
  - If `pc` ≠ `prev_pc`: `pc_change_cnt` += 1, stall counter ← 0, push `pc` into trace. Otherwise stall counter += 1.
  - `prev_pc` ← `pc`.
  - Halt check uses the post-update values, priority ADDR > STALL > TIMEOUT:
    - ADDR: `pc` == HALT_ADDR.
    - STALL: new stall count == STALL_LIMIT−1, i.e. STALL_LIMIT identical consecutive samples.
    - TIMEOUT: new `cycle_cnt` == TIMEOUT.
  - On any hit: next state HALTED, `halt` ← 1, `halt_cause` ← winning cause, `halt_pc` ← `pc`.
- HALTED: all registers frozen; `en` and `pc` are ignored.
- Latency: `halt` rises on the clk edge that samples the triggering `pc`, so it is visible one cycle after that `pc` is presented.
- `en`=0 in any state: hold everything. The stall counter does not advance, and the gap does not break PC continuity.
- Counters saturate at all-ones and never wrap.
- Stall counter is $clog2(STALL_LIMIT+1) bits wide.
- Trace buffer:
  - Ring of TRACE_DEPTH entries. A push writes at `wptr`, then `wptr` += 1 modulo TRACE_DEPTH.
  - Read is combinational: `trace_pc` = `entry[wptr−1−trace_idx]` modulo TRACE_DEPTH.
  - Fewer than TRACE_DEPTH pushes: unwritten entries read 0.

Optional Feature:
- Macro PC_TRACE_BUFFER_EN.
- Defined: trace ring buffer and `trace_pc` behave as above.
- Undefined: no trace storage or write pointer is built; `trace_pc` is tied to 32'h0 and `trace_idx` is ignored.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package `xgriscv_mon_pkg` holds:
  - `halt_cause_t` (NONE/ADDR/STALL/TIMEOUT, 2-bit);
  - `mon_state_t` (ARM/RUN/HALTED);
  - the default HALT_ADDR constant, shared with the bench.
- One natural sub-module: `pc_trace_ring` (ring storage, write pointer, indexed read). It is instantiated only under PC_TRACE_BUFFER_EN.

Test Plan:
- Linear PCs: 0,4,8,…,0xCC8,0xCCC with `en`=1 → `halt`=1 after 0xCCC is sampled, cause=1, `halt_pc`=0xCCC, `cycle_cnt`=820, `pc_change_cnt`=819.
- Self-loop: 0,4,8 then hold 8, STALL_LIMIT=16 → `halt` on the 16th consecutive 8 sample, cause=2, `halt_pc`=8, `pc_change_cnt`=2.
- TIMEOUT=50 with alternating 0/4, never HALT_ADDR → halt at `cycle_cnt`=50, cause=3. Same sample also equal to HALT_ADDR → cause=1 (priority).
- `en`=0 for 10 cycles mid-run with `pc` held → counters and stall counter unchanged, no halt. Assert `rstn` for 1 cycle while halted → all outputs 0, state ARM.
- Trace (macro on): push 10 distinct PCs 0x100..0x124 step 4 → `trace_idx` 0 reads 0x124, 7 reads 0x108 (wrap verified). After only 3 pushes, idx 5 reads 0.
- Macro off: same stimulus → `trace_pc`=0 for all idx; halt and counter results identical to the macro-on run.
